// File: rtl/zio_pkg.sv
// zio_pkg: shared state encoding and sizing helpers
// for the multi-window expansion bus controller.
package zio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } zio_state_t;

  // Channel index width: clog2 of the channel count, at least 1.
  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/zio_wait_timer.sv
// zio_wait_timer: loadable counter with a terminal flag.
// UP=0 counts down to zero, UP=1 counts up and saturates at limit.
module zio_wait_timer #(
  parameter int W  = 4,
  parameter bit UP = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] limit,
  output logic         term
);

  logic [W-1:0] cnt;

  // Counter register: clear beats load beats step; never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (step) begin
      if (UP) begin
        if (cnt != limit) cnt <= cnt + 1'b1;
      end else begin
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end

  assign term = (cnt == limit);

endmodule

// File: rtl/zio_window_ctrl.sv
// zio_window_ctrl: NUM_CH-window decoder and 68000 bus-cycle FSM.
// Optional bus-error timeout built when ZIO_BUS_TIMEOUT_EN is defined.
module zio_window_ctrl
  import zio_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int WAIT_W      = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     CLKCPU,
  input  logic                     RESET,
  input  logic [7:0]               A_HIGH,
  input  logic                     RW_n,
  input  logic                     AS_CPU_n,
  input  logic [NUM_CH*8-1:0]      BASE,
  input  logic [NUM_CH*8-1:0]      MASK,
  input  logic [NUM_CH-1:0]        CONFIGURED_n,
  input  logic [NUM_CH*WAIT_W-1:0] WAIT,
  output logic [NUM_CH-1:0]        CH_SEL,
  output logic [NUM_CH-1:0]        ROM_OE_n,
  output logic                     DTACK_n,
  output logic                     ACCESS,
  output logic                     BERR_n
);

  localparam int CH_IDX_W = ch_idx_w(NUM_CH);
  localparam logic [WAIT_W-1:0] WAIT_ONE = 1;

  if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("zio_window_ctrl: unsupported parameter values");
  end

  zio_state_t          state_q, state_d;
  logic [CH_IDX_W-1:0] ch_q, ch_d;
  logic                rw_q, rw_d;
  logic [NUM_CH-1:0]   hit;
  logic                hit_any;
  logic [CH_IDX_W-1:0] hit_idx;
  logic [WAIT_W-1:0]   hit_wait;
  logic [NUM_CH-1:0]   sel_d;
  logic                t_load, t_step, t_clr, t_term;

  // Per-channel window compare, gated by autoconfig done.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = !CONFIGURED_n[i] &&
               ((A_HIGH & MASK[8*i +: 8]) ==
                (BASE[8*i +: 8] & MASK[8*i +: 8]));
    end
  end

  assign hit_any = |hit;

  // Priority encoder: the lowest hitting index wins.
  always_comb begin
    hit_idx  = '0;
    hit_wait = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_idx  = i[CH_IDX_W-1:0];
        hit_wait = WAIT[WAIT_W*i +: WAIT_W];
      end
    end
  end

  // Next-state logic for the bus-cycle FSM.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rw_d    = rw_q;
    t_load  = 1'b0;
    t_step  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!AS_CPU_n && hit_any) begin
          ch_d    = hit_idx;
          rw_d    = RW_n;
          t_load  = 1'b1;
          state_d = (hit_wait == '0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (AS_CPU_n) begin
          state_d = ST_IDLE;
        end else if (t_term) begin
          state_d = ST_ACK;
        end else begin
          t_step = 1'b1;
        end
      end
      ST_ACK: begin
        if (AS_CPU_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign t_clr = (state_q != ST_IDLE) && (state_d == ST_IDLE);

  // Next one-hot select, decoded from the latched channel.
  always_comb begin
    sel_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_d[i] = (state_d != ST_IDLE) &&
                 (ch_d == i[CH_IDX_W-1:0]);
    end
  end

  zio_wait_timer #(
    .W  (WAIT_W),
    .UP (1'b0)
  ) u_wait (
    .clk      (CLKCPU),
    .rst      (RESET),
    .clr      (t_clr),
    .load     (t_load),
    .step     (t_step),
    .load_val (hit_wait),
    .limit    (WAIT_ONE),
    .term     (t_term)
  );

  // State, latched cycle info and registered outputs.
  always_ff @(posedge CLKCPU or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      rw_q     <= 1'b0;
      CH_SEL   <= '0;
      ROM_OE_n <= '1;
      DTACK_n  <= 1'b1;
      ACCESS   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      rw_q     <= rw_d;
      CH_SEL   <= sel_d;
      ROM_OE_n <= ~(sel_d & {NUM_CH{rw_d}});
      DTACK_n  <= (state_d != ST_ACK);
      ACCESS   <= |sel_d;
    end
  end

`ifdef ZIO_BUS_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);

  logic to_clr, to_step, to_term;

  // Unclaimed strobes in IDLE count up; strobe release or a hit clears.
  assign to_clr  = AS_CPU_n || ((state_q == ST_IDLE) && hit_any);
  assign to_step = (state_q == ST_IDLE) && !AS_CPU_n && !hit_any;

  zio_wait_timer #(
    .W  (TO_W),
    .UP (1'b1)
  ) u_timeout (
    .clk      (CLKCPU),
    .rst      (RESET),
    .clr      (to_clr),
    .load     (1'b0),
    .step     (to_step),
    .load_val ({TO_W{1'b0}}),
    .limit    (TO_LIM),
    .term     (to_term)
  );

  assign BERR_n = !to_term;
`else
  assign BERR_n = 1'b1;
`endif

endmodule

// File: tb/tb_zio_window_ctrl.sv
// tb_zio_window_ctrl: directed checks of decode, wait states,
// abort, priority, reset and (with ZIO_BUS_TIMEOUT_EN) bus timeout.
module tb_zio_window_ctrl;

  logic        CLKCPU;
  logic        RESET;
  logic [7:0]  A_HIGH;
  logic        RW_n;
  logic        AS_CPU_n;
  logic [15:0] BASE;
  logic [15:0] MASK;
  logic [1:0]  CONFIGURED_n;
  logic [7:0]  WAIT;
  logic [1:0]  CH_SEL;
  logic [1:0]  ROM_OE_n;
  logic        DTACK_n;
  logic        ACCESS;
  logic        BERR_n;

  int n_checks = 0;
  int n_fail   = 0;

  zio_window_ctrl #(
    .NUM_CH      (2),
    .WAIT_W      (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .CLKCPU       (CLKCPU),
    .RESET        (RESET),
    .A_HIGH       (A_HIGH),
    .RW_n         (RW_n),
    .AS_CPU_n     (AS_CPU_n),
    .BASE         (BASE),
    .MASK         (MASK),
    .CONFIGURED_n (CONFIGURED_n),
    .WAIT         (WAIT),
    .CH_SEL       (CH_SEL),
    .ROM_OE_n     (ROM_OE_n),
    .DTACK_n      (DTACK_n),
    .ACCESS       (ACCESS),
    .BERR_n       (BERR_n)
  );

  initial CLKCPU = 1'b0;
  always #5 CLKCPU = ~CLKCPU;

  task automatic tick();
    @(posedge CLKCPU);
    #1;
  endtask

  task automatic setup_single(input logic [3:0] w0);
    BASE         = {8'h00, 8'hE9};
    MASK         = {8'h00, 8'hFF};
    CONFIGURED_n = 2'b10;
    WAIT         = {4'd0, w0};
    A_HIGH       = 8'hE9;
  endtask

  task automatic test_reset();
    RESET    = 1'b1;
    AS_CPU_n = 1'b1;
    RW_n     = 1'b1;
    A_HIGH   = 8'h00;
    BASE     = '0;
    MASK     = '0;
    CONFIGURED_n = 2'b11;
    WAIT     = '0;
    #3;
    n_checks++;
    if ({CH_SEL, ROM_OE_n, DTACK_n, ACCESS, BERR_n} !== 7'b00_11_1_0_1) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want %b",
               {CH_SEL, ROM_OE_n, DTACK_n, ACCESS, BERR_n}, 7'b0011101);
    end
    tick();
    tick();
    #4;
    RESET = 1'b0;
    tick();
    n_checks++;
    if ({CH_SEL, DTACK_n} !== 3'b001) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b want 001", {CH_SEL, DTACK_n});
    end
  endtask

  // Read with WAIT0=3: select at k, DTACK at k+3, release after AS high.
  task automatic test_read_wait3();
    setup_single(4'd3);
    RW_n     = 1'b1;
    AS_CPU_n = 1'b0;
    tick();
    n_checks++;
    if ({CH_SEL, ROM_OE_n, DTACK_n, ACCESS} !== 6'b01_10_1_1) begin
      n_fail++;
      $display("FAIL read_k: got %b want 011011",
               {CH_SEL, ROM_OE_n, DTACK_n, ACCESS});
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (DTACK_n !== ((i == 3) ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL read_dtack_k+%0d: got %b want %b",
                 i, DTACK_n, (i == 3) ? 1'b0 : 1'b1);
      end
    end
    AS_CPU_n = 1'b1;
    tick();
    n_checks++;
    if ({CH_SEL, ROM_OE_n, DTACK_n, ACCESS} !== 6'b00_11_1_0) begin
      n_fail++;
      $display("FAIL read_release: got %b want 001110",
               {CH_SEL, ROM_OE_n, DTACK_n, ACCESS});
    end
  endtask

  // Write: no ROM enable; address changes mid-cycle are ignored.
  task automatic test_write();
    setup_single(4'd3);
    RW_n     = 1'b0;
    AS_CPU_n = 1'b0;
    tick();
    n_checks++;
    if ({CH_SEL, ROM_OE_n, DTACK_n} !== 5'b01_11_1) begin
      n_fail++;
      $display("FAIL write_k: got %b want 01111", {CH_SEL, ROM_OE_n, DTACK_n});
    end
    A_HIGH = 8'h00;
    WAIT   = {4'd0, 4'd9};
    tick();
    tick();
    n_checks++;
    if ({CH_SEL, DTACK_n} !== 3'b01_1) begin
      n_fail++;
      $display("FAIL write_k+2: got %b want 011", {CH_SEL, DTACK_n});
    end
    tick();
    n_checks++;
    if ({CH_SEL, ROM_OE_n, DTACK_n} !== 5'b01_11_0) begin
      n_fail++;
      $display("FAIL write_k+3: got %b want 01110", {CH_SEL, ROM_OE_n, DTACK_n});
    end
    AS_CPU_n = 1'b1;
    RW_n     = 1'b1;
    tick();
    n_checks++;
    if ({CH_SEL, DTACK_n} !== 3'b00_1) begin
      n_fail++;
      $display("FAIL write_release: got %b want 001", {CH_SEL, DTACK_n});
    end
  endtask

  // Overlapping windows: lowest index wins; unmatched address ignored.
  task automatic test_overlap();
    BASE         = {8'hE9, 8'hE8};
    MASK         = {8'hFF, 8'hFE};
    CONFIGURED_n = 2'b00;
    WAIT         = {4'd0, 4'd0};
    A_HIGH       = 8'hE9;
    RW_n         = 1'b1;
    AS_CPU_n     = 1'b0;
    tick();
    n_checks++;
    if ({CH_SEL, ROM_OE_n, DTACK_n} !== 5'b01_10_0) begin
      n_fail++;
      $display("FAIL overlap_e9: got %b want 01100", {CH_SEL, ROM_OE_n, DTACK_n});
    end
    AS_CPU_n = 1'b1;
    tick();
    A_HIGH   = 8'hEA;
    AS_CPU_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({CH_SEL, ROM_OE_n, DTACK_n, ACCESS} !== 6'b00_11_1_0) begin
      n_fail++;
      $display("FAIL overlap_ea: got %b want 001110",
               {CH_SEL, ROM_OE_n, DTACK_n, ACCESS});
    end
    AS_CPU_n = 1'b1;
    tick();
  endtask

  // Channel 1 alone: WAIT1=0 acks on the hit edge, one-hot bit 1.
  task automatic test_zero_wait();
    BASE         = {8'hE9, 8'h10};
    MASK         = {8'hFF, 8'hFF};
    CONFIGURED_n = 2'b01;
    WAIT         = {4'd0, 4'd7};
    A_HIGH       = 8'hE9;
    RW_n         = 1'b1;
    AS_CPU_n     = 1'b0;
    tick();
    n_checks++;
    if ({CH_SEL, ROM_OE_n, DTACK_n, ACCESS} !== 6'b10_01_0_1) begin
      n_fail++;
      $display("FAIL zero_wait_k: got %b want 100101",
               {CH_SEL, ROM_OE_n, DTACK_n, ACCESS});
    end
    AS_CPU_n = 1'b1;
    tick();
  endtask

  // Abort: AS released during WAIT ends the cycle with no DTACK.
  task automatic test_abort();
    setup_single(4'd5);
    RW_n     = 1'b1;
    AS_CPU_n = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if ({CH_SEL, DTACK_n} !== 3'b01_1) begin
      n_fail++;
      $display("FAIL abort_k+2: got %b want 011", {CH_SEL, DTACK_n});
    end
    AS_CPU_n = 1'b1;
    tick();
    n_checks++;
    if ({CH_SEL, ROM_OE_n, DTACK_n} !== 5'b00_11_1) begin
      n_fail++;
      $display("FAIL abort_k+3: got %b want 00111", {CH_SEL, ROM_OE_n, DTACK_n});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (DTACK_n !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_no_dtack: got %b want 1", DTACK_n);
      end
    end
  endtask

  // ACK exit needs an AS-high edge; the very next strobe starts a cycle.
  task automatic test_back_to_back();
    setup_single(4'd0);
    RW_n     = 1'b1;
    AS_CPU_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (DTACK_n !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_hold_ack: got %b want 0", DTACK_n);
    end
    AS_CPU_n = 1'b1;
    tick();
    n_checks++;
    if ({CH_SEL, DTACK_n} !== 3'b00_1) begin
      n_fail++;
      $display("FAIL b2b_gap: got %b want 001", {CH_SEL, DTACK_n});
    end
    AS_CPU_n = 1'b0;
    tick();
    n_checks++;
    if ({CH_SEL, DTACK_n} !== 3'b01_0) begin
      n_fail++;
      $display("FAIL b2b_second: got %b want 010", {CH_SEL, DTACK_n});
    end
    AS_CPU_n = 1'b1;
    tick();
  endtask

  // Unconfigured window never decodes; timeout raises BERR if built.
  task automatic test_unconfigured();
    logic exp_berr;
    setup_single(4'd0);
    CONFIGURED_n = 2'b11;
    RW_n         = 1'b1;
    AS_CPU_n     = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
`ifdef ZIO_BUS_TIMEOUT_EN
      exp_berr = (i >= 8) ? 1'b0 : 1'b1;
`else
      exp_berr = 1'b1;
`endif
      n_checks++;
      if ({CH_SEL, DTACK_n, BERR_n} !== {2'b00, 1'b1, exp_berr}) begin
        n_fail++;
        $display("FAIL unconf_edge%0d: got %b want %b", i,
                 {CH_SEL, DTACK_n, BERR_n}, {2'b00, 1'b1, exp_berr});
      end
    end
    AS_CPU_n = 1'b1;
    tick();
    n_checks++;
    if (BERR_n !== 1'b1) begin
      n_fail++;
      $display("FAIL unconf_berr_release: got %b want 1", BERR_n);
    end
  endtask

  // Asynchronous reset in ACK, then a normal cycle afterwards.
  task automatic test_reset_mid();
    setup_single(4'd0);
    RW_n     = 1'b1;
    AS_CPU_n = 1'b0;
    tick();
    #2;
    RESET = 1'b1;
    #1;
    n_checks++;
    if ({CH_SEL, ROM_OE_n, DTACK_n, ACCESS} !== 6'b00_11_1_0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b want 001110",
               {CH_SEL, ROM_OE_n, DTACK_n, ACCESS});
    end
    #2;
    RESET    = 1'b0;
    AS_CPU_n = 1'b1;
    tick();
    AS_CPU_n = 1'b0;
    tick();
    n_checks++;
    if ({CH_SEL, ROM_OE_n, DTACK_n} !== 5'b01_10_0) begin
      n_fail++;
      $display("FAIL reset_mid_rerun: got %b want 01100",
               {CH_SEL, ROM_OE_n, DTACK_n});
    end
    AS_CPU_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_wait3();
    tick();
    test_write();
    tick();
    test_overlap();
    test_zero_wait();
    test_abort();
    test_back_to_back();
    test_unconfigured();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zio_window_ctrl.md
# zio_window_ctrl

Parametrised multi-window address decoder and bus-cycle controller for the 68000-side expansion bus. It generalises the single-window SDIO decode to NUM_CH autoconfigured windows, each with its own base, size mask and wait-state count. It also tracks each CPU bus cycle with a state machine that drives registered per-channel selects, ROM output enables and DTACK_n. It sits between the CPU address/strobe pins and the on-board ROM and peripheral chip-selects.

## Interface
Parameters:
- NUM_CH, 2: number of decoded windows (1..8).
- WAIT_W, 4: width of each per-channel wait-state count.
- TIMEOUT_CYC, 255: cycles of unclaimed AS before bus error; used only with the Configuration macro.

Ports:
- CLKCPU  in  1  CPU clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- A_HIGH  in  8  CPU address bits 23:16.
- RW_n  in  1  CPU read/write, high = read.
- AS_CPU_n  in  1  CPU address strobe, active low.
- BASE  in  NUM_CH*8  per-channel base address bits 23:16; channel i occupies [8i+7:8i].
- MASK  in  NUM_CH*8  per-channel compare mask; 1 = bit compared.
- CONFIGURED_n  in  NUM_CH  per-channel autoconfig done, active low.
- WAIT  in  NUM_CH*WAIT_W  per-channel wait states before DTACK.
- CH_SEL  out  NUM_CH  one-hot registered select of the active channel.
- ROM_OE_n  out  NUM_CH  per-channel read output enable, active low.
- DTACK_n  out  1  data acknowledge, active low.
- ACCESS  out  1  OR of CH_SEL.
- BERR_n  out  1  bus error, active low; constant 1 without the macro.

## Operation
- Hit for channel i: !CONFIGURED_n[i] and (A_HIGH & MASK[i]) == (BASE[i] & MASK[i]). When several channels hit, the lowest index wins.
- States: IDLE, WAIT, ACK.
- IDLE: on a sampled edge with AS_CPU_n=0 and a hit, latch channel index, RW_n and cnt=WAIT[ch].
  - If cnt==0, go to ACK.
  - Otherwise go to WAIT.
- WAIT:
  - If AS_CPU_n=1, the cycle is aborted: go to IDLE with no DTACK.
  - Else if cnt==1, go to ACK.
  - Else decrement cnt.
- ACK: hold until a sampled AS_CPU_n=1, then go to IDLE.
- A new cycle is never accepted in the same edge that leaves ACK; at least one IDLE cycle always follows.
- CH_SEL[ch]=1 in WAIT and ACK. ROM_OE_n[ch] = !(CH_SEL[ch] && latched RW_n). DTACK_n=0 only in ACK.
- Address, mask and WAIT changes during WAIT or ACK have no effect on the cycle in progress, because they are latched.
- No hit in IDLE: stay in IDLE with all outputs inactive.

## Timing
- Reset values: state IDLE, cnt 0, CH_SEL 0, ROM_OE_n all 1, DTACK_n 1, ACCESS 0, BERR_n 1, timeout counter 0.
- Reset mid-cycle returns to IDLE immediately and releases all outputs asynchronously.
- Hit sampled at edge k:
  - CH_SEL and ROM_OE_n are valid after edge k.
  - DTACK_n goes low after edge k+WAIT[ch].
  - With WAIT=0, DTACK_n goes low after edge k.
- DTACK_n and CH_SEL release after the first edge that samples AS_CPU_n=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- ZIO_BUS_TIMEOUT_EN defined:
  - In IDLE, a counter increments each edge with AS_CPU_n=0 and no hit; it clears when AS_CPU_n=1.
  - When the count reaches TIMEOUT_CYC, BERR_n goes low. It stays low until AS_CPU_n=1 is sampled, and the counter then clears.
  - The count saturates and never wraps.
  - A hit clears the counter.
- ZIO_BUS_TIMEOUT_EN undefined: the timeout counter is not built and BERR_n is tied to 1.

## Structure
- Shared package zio_pkg: state enum (IDLE/WAIT/ACK) and a CH_IDX_W constant/function, clog2 of NUM_CH with a minimum of 1.
- Sub-module zio_wait_timer: loadable down-counter with a terminal flag, WAIT_W wide. It is reused as the saturating timeout counter when the macro is on.
- Top module: hit compare, priority encoder, FSM and output registers.

## Test plan
- NUM_CH=2, BASE0=0xE9, MASK0=0xFF, CONFIGURED_n=2'b10, WAIT0=3, read at A_HIGH=0xE9 -> CH_SEL=01 and ROM_OE_n[0]=0 after edge k; DTACK_n low after edge k+3; all release one edge after AS high.
- Same setup, write (RW_n=0) -> ROM_OE_n stays 1; CH_SEL and DTACK timing unchanged.
- Overlap: BASE0=0xE8 MASK0=0xFE and BASE1=0xE9 MASK1=0xFF, both configured, access 0xE9 -> channel 0 selected; access 0xEA -> no select.
- WAIT0=0 -> DTACK_n low after edge k. Abort: WAIT0=5 with AS raised at k+2 -> DTACK never asserts, IDLE at k+3.
- Unconfigured channel (CONFIGURED_n=1) matching address -> no outputs. With ZIO_BUS_TIMEOUT_EN and TIMEOUT_CYC=8, AS held low -> BERR_n low after 8 edges, released after AS high.
- Assert RESET during ACK -> DTACK_n=1 and CH_SEL=0 immediately; the next hit after release runs normally.
